crc_frame_tx: RTL and testbench

CRC_FRAME_TX -- requirements
Module: crc_frame_tx

---
 rtl/crc_frame_tx_pkg.sv | 13 +
 rtl/crc_frame_tx_step.sv | 27 ++
 rtl/crc_frame_tx.sv | 131 +++++++++++++
 tb/tb_crc_frame_tx.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_frame_tx_pkg.sv
// Shared types and default constants for the CRC frame transmitter.
package crc_frame_tx_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BODY    = 2'd1,
      TRAILER = 2'd2
   } state_t;

   localparam logic [7:0] DEFAULT_POLY = 8'h07;
   localparam logic [7:0] DEFAULT_INIT = 8'h00;

endpackage

// File: rtl/crc_frame_tx_step.sv
// One-beat CRC update: MSB-first, non-reflected, no final XOR.
module crc_frame_tx_step
   import crc_frame_tx_pkg::*;
#(
   parameter int                           POLYNOMIAL_BITS = 8,
   parameter int                           DATA_WIDTH      = 8,
   parameter logic [POLYNOMIAL_BITS-1:0]   POLY            = POLYNOMIAL_BITS'(DEFAULT_POLY)
) (
   input  logic [POLYNOMIAL_BITS-1:0] crc_in,
   input  logic [DATA_WIDTH-1:0]      data,
   output logic [POLYNOMIAL_BITS-1:0] crc_out
);

   logic [POLYNOMIAL_BITS-1:0] w_crc;
   logic                       w_fb;

   always_comb begin
      w_crc = crc_in;
      w_fb  = 1'b0;
      for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
         w_fb  = w_crc[POLYNOMIAL_BITS-1] ^ data[i];
         w_crc = (w_crc << 1) ^ (w_fb ? POLY : '0);
      end
      crc_out = w_crc;
   end

endmodule

// File: rtl/crc_frame_tx.sv
// Frames a payload stream and appends a CRC trailer beat after the last beat.
// Optional trailer corruption is enabled with CRC_FRAME_TX_ERR_INJECT_EN.
module crc_frame_tx
   import crc_frame_tx_pkg::*;
#(
   parameter int                           DATA_WIDTH      = 8,
   parameter int                           POLYNOMIAL_BITS = 8,
   parameter logic [POLYNOMIAL_BITS-1:0]   POLY            = POLYNOMIAL_BITS'(DEFAULT_POLY),
   parameter logic [POLYNOMIAL_BITS-1:0]   INIT            = POLYNOMIAL_BITS'(DEFAULT_INIT)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   input  logic                  in_last,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   output logic                  out_last,
   output logic                  out_is_crc,
   input  logic                  out_ready,
   input  logic                  err_inject,
   output logic [15:0]           frames_sent
);

   // Handshake: a beat moves on a port when valid && ready are both high at a
   // rising edge; valid never depends on ready, and held output beats stay stable.
   state_t                     r_state;
   state_t                     w_next_state;
   logic [POLYNOMIAL_BITS-1:0] r_crc;
   logic [DATA_WIDTH-1:0]      r_out_data;
   logic                       r_out_valid;
   logic                       r_out_last;
   logic                       r_out_is_crc;
   logic [15:0]                r_frames_sent;

   logic                       w_out_free;
   logic                       w_accept;
   logic                       w_trailer_load;
   logic [POLYNOMIAL_BITS-1:0] w_seed;
   logic [POLYNOMIAL_BITS-1:0] w_crc_next;
   logic [POLYNOMIAL_BITS-1:0] w_trailer;

   assign w_out_free     = !r_out_valid || out_ready;
   assign in_ready       = rst_n && (r_state != TRAILER) && w_out_free;
   assign w_accept       = in_valid && in_ready;
   assign w_trailer_load = (r_state == TRAILER) && w_out_free;
   // A frame opened from IDLE restarts from the seed, so a partial frame cut by reset leaves no trace.
   assign w_seed         = (r_state == IDLE) ? INIT : r_crc;

   crc_frame_tx_step #(
      .POLYNOMIAL_BITS (POLYNOMIAL_BITS),
      .DATA_WIDTH      (DATA_WIDTH),
      .POLY            (POLY)
   ) u_step (
      .crc_in  (w_seed),
      .data    (in_data),
      .crc_out (w_crc_next)
   );

`ifdef CRC_FRAME_TX_ERR_INJECT_EN
   logic r_inj_pending;

   // A request arriving while a trailer loads is kept for the following trailer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              r_inj_pending <= 1'b0;
      else if (err_inject)     r_inj_pending <= 1'b1;
      else if (w_trailer_load) r_inj_pending <= 1'b0;
   end

   assign w_trailer = r_crc ^ POLYNOMIAL_BITS'(r_inj_pending);
`else
   logic w_unused_err_inject;
   assign w_unused_err_inject = err_inject;
   assign w_trailer           = r_crc;
`endif

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next_state = in_last ? TRAILER : BODY;
         BODY:    if (w_accept && in_last) w_next_state = TRAILER;
         TRAILER: if (w_trailer_load) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_crc        <= INIT;
         r_out_data   <= '0;
         r_out_valid  <= 1'b0;
         r_out_last   <= 1'b0;
         r_out_is_crc <= 1'b0;
      end else begin
         if (w_accept) begin
            r_crc        <= w_crc_next;
            r_out_data   <= in_data;
            r_out_valid  <= 1'b1;
            r_out_last   <= 1'b0;
            r_out_is_crc <= 1'b0;
         end else if (w_trailer_load) begin
            r_out_data   <= DATA_WIDTH'(w_trailer);
            r_out_valid  <= 1'b1;
            r_out_last   <= 1'b1;
            r_out_is_crc <= 1'b1;
         end else if (out_ready) begin
            r_out_valid  <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_frames_sent <= 16'd0;
      else if (r_out_valid && out_ready && r_out_is_crc)
         r_frames_sent <= r_frames_sent + 16'd1;
   end

   assign out_data    = r_out_data;
   assign out_valid   = r_out_valid;
   assign out_last    = r_out_last;
   assign out_is_crc  = r_out_is_crc;
   assign frames_sent = r_frames_sent;

endmodule

// File: tb/tb_crc_frame_tx.sv
// Directed bench for crc_frame_tx: reference model by polynomial long division,
// expected-beat queue, per-cycle output compare and a final report.
module tb_crc_frame_tx;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic        in_ready;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_last;
   logic        out_is_crc;
   logic        out_ready = 1'b1;
   logic        err_inject = 1'b0;
   logic [15:0] frames_sent;

   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          last_accept_cyc = 0;
   int          frame_first_cyc = 0;
   logic [9:0]  exp_q[$];
   logic [15:0] exp_frames = 16'd0;
   logic [7:0]  frm[$];
   logic        inj_model = 1'b0;
   logic [7:0]  last_trailer = 8'h00;
   logic        stalled = 1'b0;
   logic [10:0] stall_beat = '0;
   logic [9:0]  e;

   crc_frame_tx dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_last     (in_last),
      .in_ready    (in_ready),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_last    (out_last),
      .out_is_crc  (out_is_crc),
      .out_ready   (out_ready),
      .err_inject  (err_inject),
      .frames_sent (frames_sent)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(negedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // CRC-8 (x^8+x^2+x+1, seed 0) as remainder of the message times x^8
   function automatic logic [7:0] crc_model();
      logic [8:0] rem;
      logic       b;
      rem = 9'd0;
      for (int i = 0; i < frm.size() + 1; i++) begin
         for (int k = 7; k >= 0; k--) begin
            b = (i < frm.size()) ? frm[i][k] : 1'b0;
            rem = {rem[7:0], b};
            if (rem[8]) rem = rem ^ 9'h107;
         end
      end
      return rem[7:0];
   endfunction

   // scoreboard / compare process
   always @(negedge clk) begin
      if (rst_n) begin
         if (stalled)
            check("hold_stable", {out_valid, out_last, out_is_crc, out_data}, stall_beat);
         check("frames_sent", frames_sent, exp_frames);
         if (out_valid && !out_ready)
            check("in_ready_while_stalled", in_ready, 1'b0);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_beat: got 0x%0h, expected no beat", {out_data, out_last, out_is_crc});
            end else begin
               e = exp_q.pop_front();
               check("out_beat", {out_data, out_last, out_is_crc}, e);
               if (e[0]) begin
                  exp_frames = exp_frames + 16'd1;
                  last_trailer = out_data;
               end
            end
         end
         stalled    = out_valid && !out_ready;
         stall_beat = {out_valid, out_last, out_is_crc, out_data};
      end else begin
         stalled = 1'b0;
      end
   end

   // driver tasks: called just after a rising edge
   task automatic send_beat(input logic [7:0] d, input logic last);
      int waited;
      waited   = 0;
      in_data  = d;
      in_valid = 1'b1;
      in_last  = last;
      @(negedge clk);
      while (!in_ready && waited < 100) begin
         waited++;
         @(negedge clk);
      end
      if (!in_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, expected acceptance", waited);
      end
      @(posedge clk);
      last_accept_cyc = cyc;
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_frame();
      logic [7:0] t;
      for (int i = 0; i < frm.size(); i++) exp_q.push_back({frm[i], 2'b00});
      t = crc_model() ^ {7'd0, inj_model};
      exp_q.push_back({t, 2'b11});
      inj_model = 1'b0;
      for (int i = 0; i < frm.size(); i++) begin
         send_beat(frm[i], (i == frm.size() - 1));
         if (i == 0) frame_first_cyc = last_accept_cyc;
      end
   endtask

   task automatic drain();
      int waited;
      waited = 0;
      while ((exp_q.size() != 0 || out_valid) && waited < 100) begin
         waited++;
         @(posedge clk);
         #1;
      end
      if (exp_q.size() != 0 || out_valid) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_timeout: got %0d beats outstanding, expected 0", exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_inject();
      err_inject = 1'b1;
`ifdef CRC_FRAME_TX_ERR_INJECT_EN
      inj_model = 1'b1;
`endif
      @(posedge clk);
      #1;
      err_inject = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] inj_trailer;
      int         diff;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_last", out_last, 1'b0);
      check("rst_out_is_crc", out_is_crc, 1'b0);
      check("rst_out_data", out_data, 8'h00);
      check("rst_frames_sent", frames_sent, 16'h0000);
      check("rst_in_ready", in_ready, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // single-beat frame
      frm = '{8'h01};
      check("model_pin_01", crc_model(), 8'h07);
      send_frame();
      drain();
      check("single_trailer", last_trailer, 8'h07);
      check("single_frames_sent", frames_sent, 16'd1);

      // check string "123456789"
      frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      check("model_pin_check", crc_model(), 8'hF4);
      send_frame();
      drain();
      check("check_trailer", last_trailer, 8'hF4);

      // same frame with a 5-cycle downstream stall mid-frame
      fork
         send_frame();
         begin
            repeat (4) @(posedge clk);
            #1;
            out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();
      check("stall_trailer", last_trailer, 8'hF4);
      check("stall_frames_sent", frames_sent, 16'd3);

      // back-to-back 3-beat frames: one bubble per trailer
      frm = '{8'hA5, 8'h5A, 8'hFF};
      send_frame();
      diff = frame_first_cyc;
      frm = '{8'h00, 8'h80, 8'h7E};
      send_frame();
      check("b2b_accept_span", last_accept_cyc - diff, 6);
      drain();
      check("b2b_frames_sent", frames_sent, 16'd5);

      // reset mid-frame discards the partial frame
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back({8'h10 + 8'(i), 2'b00});
         send_beat(8'h10 + 8'(i), 1'b0);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      exp_frames = 16'd0;
      in_data  = 8'h99;
      in_valid = 1'b1;
      @(negedge clk);
      check("midrst_in_ready", in_ready, 1'b0);
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_frames_sent", frames_sent, 16'd0);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      frm = '{8'h01};
      send_frame();
      drain();
      check("post_rst_trailer", last_trailer, 8'h07);
      check("post_rst_frames_sent", frames_sent, 16'd1);

      // error injection: corrupts only the next trailer when enabled
`ifdef CRC_FRAME_TX_ERR_INJECT_EN
      inj_trailer = 8'h06;
`else
      inj_trailer = 8'h07;
`endif
      pulse_inject();
      frm = '{8'h01};
      send_frame();
      drain();
      check("inject_trailer", last_trailer, inj_trailer);
      send_frame();
      drain();
      check("after_inject_trailer", last_trailer, 8'h07);

      // frames_sent wraps from 16'hFFFF to 0
      @(posedge clk);
      #1;
      force dut.r_frames_sent = 16'hFFFF;
      exp_frames = 16'hFFFF;
      @(posedge clk);
      #1;
      release dut.r_frames_sent;
      @(posedge clk);
      #1;
      check("wrap_preload", frames_sent, 16'hFFFF);
      frm = '{8'h01};
      send_frame();
      drain();
      check("wrap_frames_sent", frames_sent, 16'h0000);
      check("wrap_trailer", last_trailer, 8'h07);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
